load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU: takes the ALU result as effective address, plus store data and memory control from the decoder.
- Runs a multi-cycle request/acknowledge transaction on the data bus and stalls the single-cycle core until the access completes.
- Returns a load value, aligned and extended, to the writeback mux.
- Handles byte, halfword and word lanes (little-endian), misalignment detection and a bus timeout.

Parameters:
- TIMEOUT, default 16: WAIT-state cycles without ack before a bus error is declared; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- addr  input  32  effective address (ALU result)
- store_data  input  32  rt value, unshifted
- mem_read  input  1  load requested this instruction
- mem_write  input  1  store requested this instruction
- size  input  2  access size, mem_pkg encoding
- sign_ext  input  1  load sign-extends when 1, zero-extends when 0
- load_data  output  32  aligned/extended load result, valid in DONE
- stall  output  1  hold PC and pipeline when 1
- misalign  output  1  access misaligned, no bus transaction issued
- bus_err  output  1  timeout, asserted only in DONE
- bus_req  output  1  bus request, registered
- bus_we  output  1  write strobe, registered
- bus_addr  output  32  word address {addr[31:2],2'b00}, registered
- bus_be  output  4  byte enables, registered
- bus_wdata  output  32  lane-replicated store data, registered
- bus_rdata  input  32  read data, sampled on ack
- bus_ack  input  1  transaction complete

Behaviour:
- Reset (async, rst_n=0): state IDLE. All registered outputs are 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, bus_err. The timeout counter is 0.
- Access is active (act) when mem_read|mem_write. If both are set, the access is a write.
- Misaligned when: half with addr[0]=1, or word with addr[1:0]!=0. size=2'b11 is also treated as misaligned.
- misalign = IDLE & act & misaligned (combinational). With misalign=1: stall=0, no bus activity, state stays IDLE.
- stall = (IDLE & act & ~misaligned) | WAIT (combinational). In DONE, stall=0.
- IDLE:
  - On aligned act, register bus_addr, bus_be, bus_wdata and bus_we, set bus_req=1, and go to WAIT.
  - Also clear bus_err, and clear the counter.
- WAIT:
  - bus_req, bus_addr, bus_be, bus_wdata and bus_we are held stable.
  - On bus_ack: drop bus_req. For a read, capture the extracted value into load_data. Go to DONE.
  - Otherwise the counter increments. When TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: drop bus_req, set bus_err=1, set load_data=0, go to DONE.
- DONE:
  - Lasts one cycle; the core advances at the end of it. Go to IDLE unconditionally; act is not re-sampled in DONE, so no double issue.
  - bus_err and load_data hold until the next issue.
- bus_ack in IDLE or DONE is ignored.
- Byte enables and store data:
  - byte: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{store_data[7:0]}}.
  - half: bus_be = addr[1] ? 4'b1100 : 4'b0011; bus_wdata = {2{store_data[15:0]}}.
  - word: bus_be = 4'b1111; bus_wdata = store_data.
  - For reads, bus_be is the same pattern; bus_wdata is don't-care but registered.
- Load extraction:
  - Shift bus_rdata right by 8*addr[1:0] using the registered lane.
  - Take the low 8 or 16 bits, then sign- or zero-extend per sign_ext registered at issue. Word loads pass through unchanged.
- Latency: with ack on the first bus_req cycle, the access takes 3 cycles (IDLE issue, WAIT, DONE). Each extra wait cycle adds 1.
- Reset mid-transaction: return to IDLE immediately and drop bus_req; the bus slave must tolerate an abandoned request.

Decomposition:
- mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum IDLE/WAIT/DONE;
  - TIMEOUT counter width, 16 bits.
- One combinational sub-module, load_align, inputs: rdata, byte offset, size, sign_ext; output: the 32-bit result.
- The FSM, counter and bus registers stay in load_store_unit.

Test Plan:
- Word load, addr=0x100, ack on first req cycle, rdata=0xDEADBEEF -> stall=1 for 2 cycles, bus_addr=0x100, be=4'b1111, load_data=0xDEADBEEF in DONE.
- Signed byte load, addr=0x103, rdata=0x80FF1234 -> be=4'b1000, load_data=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Halfword store, addr=0x202, store_data=0x0000ABCD, ack after 3 wait cycles -> bus_we=1, be=4'b1100, wdata=0xABCDABCD, stall=1 for 5 cycles.
- Misaligned word load, addr=0x101 -> misalign=1, stall=0, bus_req stays 0, state stays IDLE.
- TIMEOUT=4, no ack -> bus_req drops after 4 WAIT cycles, bus_err=1 and load_data=0 in DONE, stall=0 in DONE.
- rst_n pulsed low during WAIT -> bus_req=0 and state IDLE immediately. After release, a new word load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states, timeout counter width.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// Request/acknowledge data bus between the load/store stage (master) and memory (slave).
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Lane extraction for loads: shift read data down by the byte offset, then zero/sign-extend.
// Purely combinational, no latency, no backpressure.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);
    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (size)
            SZ_BYTE: result = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one bus transaction per aligned load/store, 3 cycles minimum.
// Stalls the core while waiting for bus_ack; gives up with bus_err after TIMEOUT wait cycles.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                size,
    input  logic                      sign_ext,
    output logic [31:0]               load_data,
    output logic                      stall,
    output logic                      misalign,
    output logic                      bus_err,
    load_store_unit_if.master         bus
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             act;
    logic             misaligned;
    logic             issue;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       be_nxt;
    logic [31:0]      wdata_nxt;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_sext;
    logic [31:0]      aligned;

    assign act     = mem_read | mem_write;
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_nxt     = 4'b1111;
        wdata_nxt  = store_data;
        case (size)
            SZ_BYTE: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                misaligned = addr[0];
                be_nxt     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt  = {2{store_data[15:0]}};
            end
            SZ_WORD: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // act is only looked at in IDLE, so a held instruction cannot re-issue from DONE.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        misalign  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.bus_ack || tmo_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata    (bus.bus_rdata),
        .offset   (r_off),
        .size     (r_size),
        .sign_ext (r_sext),
        .result   (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            load_data     <= '0;
            bus_err       <= 1'b0;
            cnt           <= '0;
            r_off         <= '0;
            r_size        <= '0;
            r_sext        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_write;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= be_nxt;
                        bus.bus_wdata <= wdata_nxt;
                        r_off         <= addr[1:0];
                        r_size        <= size;
                        r_sext        <= sign_ext;
                        bus_err       <= 1'b0;
                        cnt           <= '0;
                    end
                end
                WAIT: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) load_data <= aligned;
                    end else if (tmo_hit) begin
                        bus.bus_req <= 1'b0;
                        bus_err     <= 1'b1;
                        load_data   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-lane reference model and a responsive bus slave.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, store_data;
    logic        mem_read, mem_write, sign_ext;
    logic [1:0]  size;
    logic [31:0] load_data;
    logic        stall, misalign, bus_err;

    int checks = 0;
    int errors = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .store_data (store_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .load_data  (load_data),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int o, input int nb, input bit sx);
        logic [31:0] v;
        v = rd >> (8 * o);
        if (nb == 1) begin
            v = v % 256;
            if (sx && v >= 128) v = v - 256;
        end else if (nb == 2) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic clear_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Entered and left just after a rising edge. dly = wait cycles before ack; dly >= TMO means no ack.
    task automatic access(input logic [31:0] a, input logic [31:0] sd, input bit rd, input bit wr,
                          input logic [1:0] sz, input bit sx, input int dly, input logic [31:0] rdat);
        int          o, nb, waits, exp_stalls, stalls;
        bit          mis, is_wr, tmo, ack_now;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        addr = a; store_data = sd; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
        if (!rd && !wr) begin
            @(negedge clk);
            chk("idle_stall", stall, 0);
            chk("idle_misalign", misalign, 0);
            @(posedge clk); #1;
            return;
        end
        o     = int'(a[1:0]);
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis   = (sz == 2'd3) || ((o % nb) != 0);
        is_wr = wr;
        @(negedge clk);
        chk("misalign", misalign, 32'(mis));
        chk("stall_issue", stall, 32'(!mis));
        if (mis) begin
            @(posedge clk); #1;
            chk("req_misaligned", bus_if.bus_req, 0);
            chk("stall_after_mis", stall, 0);
            clear_inputs();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            ebe[i]       = (i >= o) && (i < o + nb);
            ewd[8*i +: 8] = sd[8*(i % nb) +: 8];
        end
        @(posedge clk); #1;
        stalls = 1;
        chk("req", bus_if.bus_req, 1);
        chk("we", bus_if.bus_we, 32'(is_wr));
        chk("baddr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("be", bus_if.bus_be, 32'(ebe));
        if (is_wr) chk("wdata", bus_if.bus_wdata, ewd);
        waits = 0;
        tmo   = 1'b0;
        while (1) begin
            ack_now           = (waits == dly);
            bus_if.bus_ack    = ack_now;
            bus_if.bus_rdata  = ack_now ? rdat : $urandom;
            @(negedge clk);
            if (stall) stalls++;
            chk("req_hold", bus_if.bus_req, 1);
            @(posedge clk); #1;
            waits++;
            if (ack_now) break;
            if (waits == TMO) begin tmo = 1'b1; break; end
        end
        // A stray ack in DONE must be ignored.
        bus_if.bus_ack = 1'($urandom_range(0, 1));
        exp_stalls = (dly >= TMO) ? 1 + TMO : 2 + dly;
        @(negedge clk);
        chk("stall_done", stall, 0);
        chk("req_done", bus_if.bus_req, 0);
        chk("bus_err", bus_err, 32'(tmo));
        chk("stall_cycles", stalls, exp_stalls);
        if (tmo)         chk("load_tmo", load_data, 0);
        else if (!is_wr) chk("load_data", load_data, model_load(rdat, o, nb, sx));
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        chk("no_reissue", bus_if.bus_req, 0);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        addr = '0; store_data = '0; size = '0; sign_ext = 1'b0;
        clear_inputs();
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
        #12;
        chk("rst_req", bus_if.bus_req, 0);
        chk("rst_we", bus_if.bus_we, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_be", bus_if.bus_be, 0);
        chk("rst_wdata", bus_if.bus_wdata, 0);
        chk("rst_load", load_data, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(32'h100, 0, 1, 0, 2'd2, 0, 0, 32'hDEADBEEF);
        access(32'h103, 0, 1, 0, 2'd0, 1, 0, 32'h80FF1234);
        access(32'h103, 0, 1, 0, 2'd0, 0, 1, 32'h80FF1234);
        access(32'h202, 32'h0000ABCD, 0, 1, 2'd1, 0, 3, 0);
        access(32'h101, 0, 1, 0, 2'd2, 0, 0, 0);
        access(32'h400, 0, 1, 0, 2'd2, 0, 100, 0);
        access(32'h206, 32'h12345678, 1, 1, 2'd1, 1, 2, 0);

        // Reset pulse in the middle of a wait: request must vanish at once.
        addr = 32'h300; size = 2'd2; mem_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("pre_rst_req", bus_if.bus_req, 1);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_mid_req", bus_if.bus_req, 0);
        chk("rst_mid_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(32'h300, 0, 1, 0, 2'd2, 0, 1, 32'hCAFEF00D);

        for (int n = 0; n < 250; n++) begin
            logic [1:0] rw;
            rw = 2'($urandom_range(0, 3));
            access($urandom, $urandom, rw[0], rw[1], 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
